// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: default widths,
// FSM state encoding and the ALU control codes used by requesters.
package alu_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 5;
    localparam int DEF_FLAG_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_XOR = 5'b00100;

    // Priority hands over to the requester that was not just served.
    function automatic logic next_pointer(input logic [1:0] grant);
        return grant[0];
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot grant from the valids and the priority
// pointer. Purely combinational; the pointer register lives in the caller.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | ~pointer);
    assign grant[1] = valid[1] & (~valid[0] |  pointer);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// one operation at a time, returning each result on the owner's response channel.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int FLAG_W = DEF_FLAG_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_out,
    output logic [FLAG_W-1:0] resp0_flags,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_out,
    output logic [FLAG_W-1:0] resp1_flags,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags
);

    state_t            state;
    state_t            state_next;
    logic              pointer;
    logic              grant_id;
    logic [1:0]        pick;
    logic              accept;
    logic              resp_done;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [CTRL_W-1:0] op_ctrl;
    logic [DATA_W-1:0] res_out;
    logic [FLAG_W-1:0] res_flags;

    rr_pick2 u_pick (
        .valid   ({req1_valid, req0_valid}),
        .pointer (pointer),
        .grant   (pick)
    );

    // A grant only exists when its requester is valid, so any pick in IDLE is a handshake.
    assign accept    = (state == ST_IDLE) && (pick != 2'b00);
    assign resp_done = (state == ST_RESP) && (grant_id ? resp1_ready : resp0_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)    state_next = ST_EXEC;
            ST_EXEC:                state_next = ST_RESP;
            ST_RESP: if (resp_done) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = '0;
        resp0_valid = 1'b0;
        resp0_out   = '0;
        resp0_flags = '0;
        resp1_valid = 1'b0;
        resp1_out   = '0;
        resp1_flags = '0;
        case (state)
            ST_IDLE: begin
                req0_ready = pick[0];
                req1_ready = pick[1];
            end
            ST_EXEC: begin
                alu_a    = op_a;
                alu_b    = op_b;
                alu_ctrl = op_ctrl;
            end
            ST_RESP: begin
                if (grant_id) begin
                    resp1_valid = 1'b1;
                    resp1_out   = res_out;
                    resp1_flags = res_flags;
                end else begin
                    resp0_valid = 1'b1;
                    resp0_out   = res_out;
                    resp0_flags = res_flags;
                end
            end
            default: ;
        endcase
    end

    // Operand latch on accept, result capture at the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer   <= 1'b0;
            grant_id  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_ctrl   <= '0;
            res_out   <= '0;
            res_flags <= '0;
        end else begin
            if (accept) begin
                grant_id <= pick[1];
                pointer  <= next_pointer(pick);
                op_a     <= pick[1] ? req1_a    : req0_a;
                op_b     <= pick[1] ? req1_b    : req0_b;
                op_ctrl  <= pick[1] ? req1_ctrl : req0_ctrl;
            end
            if (state == ST_EXEC) begin
                res_out   <= alu_out;
                res_flags <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU (add/sub/and)
// wired to its alu_* ports; flags are {negative, zero, carry}.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic [31:0] req0_a, req0_b, resp0_out;
    logic [4:0]  req0_ctrl;
    logic [2:0]  resp0_flags;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [31:0] req1_a, req1_b, resp1_out;
    logic [4:0]  req1_ctrl;
    logic [2:0]  resp1_flags;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_ctrl;
    logic [2:0]  alu_flags;
    logic [32:0] alu_wide;

    int checks;
    int failures;

    alu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ctrl   (req0_ctrl),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_out   (resp0_out),
        .resp0_flags (resp0_flags),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ctrl   (req1_ctrl),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_out   (resp1_out),
        .resp1_flags (resp1_flags),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags)
    );

    always_comb begin
        alu_wide = '0;
        case (alu_ctrl)
            ALU_ADD: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_SUB: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_AND: alu_wide = {1'b0, alu_a & alu_b};
            default: alu_wide = '0;
        endcase
    end
    assign alu_out   = alu_wide[31:0];
    assign alu_flags = {alu_wide[31], alu_wide[31:0] == 32'd0, alu_wide[32]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0; resp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0; resp1_ready = 0;

        // Reset state
        cyc(); cyc(); #4;
        check("rst_outputs", 128'({req0_ready, req1_ready, resp0_valid, resp1_valid,
              resp0_out, resp1_out, resp0_flags, resp1_flags, alu_a, alu_b, alu_ctrl}), 128'(0));
        cyc(); rst = 1'b0;

        // Contention right after reset: req0 wins, then req1
        cyc();
        req0_valid = 1; req0_a = 512; req0_b = 1024; req0_ctrl = ALU_ADD;
        req1_valid = 1; req1_a = 150; req1_b = 4;    req1_ctrl = ALU_ADD;
        #4;
        check("cont_ready0", 128'(req0_ready), 128'(1));
        check("cont_ready1", 128'(req1_ready), 128'(0));
        cyc(); req0_valid = 0; #4;
        check("cont_exec_ready1", 128'(req1_ready), 128'(0));
        check("cont_exec_alu", 128'({alu_a, alu_b, alu_ctrl}), 128'({32'd512, 32'd1024, ALU_ADD}));
        cyc(); #4;
        check("cont_resp0_valid", 128'({resp0_valid, resp1_valid}), 128'(2'b10));
        check("cont_resp0_out", 128'(resp0_out), 128'(1536));
        resp0_ready = 1;
        cyc(); resp0_ready = 0; #4;
        check("cont_req1_ready", 128'({req1_ready, resp0_valid}), 128'(2'b10));
        cyc(); req1_valid = 0; #4;
        check("cont_exec1_alu_a", 128'(alu_a), 128'(150));
        cyc(); #4;
        check("cont_resp1_valid", 128'({resp0_valid, resp1_valid}), 128'(2'b01));
        check("cont_resp1_out", 128'({resp1_out, resp1_flags}), 128'({32'd154, 3'b000}));
        resp1_ready = 1;
        cyc(); resp1_ready = 0; #4;
        check("cont_done", 128'({resp1_valid, req0_ready, req1_ready}), 128'(0));

        // Fairness: both held valid, grants alternate from requester 0
        cyc();
        req0_valid = 1; req0_a = 100; req0_b = 5; req0_ctrl = ALU_ADD;
        req1_valid = 1; req1_a = 8;   req1_b = 50; req1_ctrl = ALU_SUB;
        resp0_ready = 1; resp1_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) cyc();
            #4;
            check("fair_grant", 128'({req0_ready, req1_ready}), 128'((i % 2 == 0) ? 2'b10 : 2'b01));
            cyc(); #4;
            check("fair_exec_ready", 128'({req0_ready, req1_ready}), 128'(0));
            cyc(); #4;
            if (i % 2 == 0) begin
                check("fair_resp0", 128'({resp0_valid, resp1_valid, resp0_out, resp0_flags}),
                      128'({2'b10, 32'd105, 3'b000}));
            end else begin
                check("fair_resp1", 128'({resp0_valid, resp1_valid, resp1_out, resp1_flags}),
                      128'({2'b01, 32'hFFFF_FFD6, 3'b101}));
            end
        end
        cyc();
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        #4;
        check("fair_end_idle", 128'({resp0_valid, resp1_valid}), 128'(0));

        // Single add on requester 0
        cyc();
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_ctrl = ALU_ADD;
        #4;
        check("single_ready", 128'({req0_ready, req1_ready}), 128'(2'b10));
        cyc(); req0_valid = 0; #4;
        check("single_exec_alu", 128'({alu_a, alu_b, alu_ctrl}), 128'({32'd1, 32'd2, ALU_ADD}));
        check("single_exec_novalid", 128'({resp0_valid, resp1_valid}), 128'(0));
        cyc(); #4;
        check("single_resp", 128'({resp0_valid, resp1_valid, resp0_out, resp0_flags}),
              128'({2'b10, 32'd3, 3'b000}));
        resp0_ready = 1;
        cyc(); resp0_ready = 0; #4;
        check("single_release", 128'({resp0_valid, resp1_valid}), 128'(0));

        // Back-pressure: resp0 stalled 5 cycles while req1 waits
        cyc();
        req0_valid = 1; req0_a = 1243; req0_b = 10; req0_ctrl = ALU_ADD;
        #4;
        check("bp_ready0", 128'(req0_ready), 128'(1));
        cyc();
        req0_valid = 0;
        req1_valid = 1; req1_a = 7; req1_b = 7; req1_ctrl = ALU_ADD;
        #4;
        check("bp_exec_ready1", 128'(req1_ready), 128'(0));
        for (int k = 0; k < 5; k++) begin
            cyc(); #4;
            check("bp_stall", 128'({resp0_valid, resp1_valid, req0_ready, req1_ready, resp0_out, resp0_flags}),
                  128'({4'b1000, 32'd1253, 3'b000}));
        end
        resp0_ready = 1;
        cyc(); resp0_ready = 0; req1_valid = 0; #4;
        check("bp_release", 128'({resp0_valid, resp1_valid}), 128'(0));

        // Reset while an op for requester 1 is in EXEC
        cyc();
        req1_valid = 1; req1_a = 1; req1_b = 2; req1_ctrl = ALU_ADD;
        #4;
        check("rexec_ready1", 128'({req0_ready, req1_ready}), 128'(2'b01));
        cyc(); req1_valid = 0; #4;
        check("rexec_in_exec", 128'(alu_a), 128'(1));
        rst = 1;
        #1;
        check("rexec_outputs_zero", 128'({req0_ready, req1_ready, resp0_valid, resp1_valid,
              resp1_out, alu_a, alu_b, alu_ctrl}), 128'(0));
        cyc(); #4;
        check("rexec_hold_resp1", 128'(resp1_valid), 128'(0));
        cyc(); rst = 0; #4;
        check("rexec_after_release", 128'({resp1_valid, alu_a}), 128'(0));
        cyc();
        req0_valid = 1; req0_a = 3; req0_b = 4; req0_ctrl = ALU_ADD;
        req1_valid = 1; req1_a = 1; req1_b = 2; req1_ctrl = ALU_ADD;
        #4;
        check("rexec_ptr_zero", 128'({req0_ready, req1_ready}), 128'(2'b10));
        cyc(); req0_valid = 0; req1_valid = 0; #4;
        cyc(); #4;
        check("rexec_resp0", 128'({resp0_valid, resp1_valid, resp0_out}), 128'({2'b10, 32'd7}));
        resp0_ready = 1;
        cyc(); resp0_ready = 0; #4;

        // Idle bus for 10 cycles
        for (int j = 0; j < 10; j++) begin
            cyc(); #4;
            check("idle_bus", 128'({alu_a, alu_b, alu_ctrl, req0_ready, req1_ready, resp0_valid, resp1_valid}),
                  128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
